// File: rtl/bwsm_mult.sv
// Baugh-Wooley signed W x W multiplier with a carry-save array, a ripple final adder and a registered output.
// Define BWSM_PIPE_EN to register the sum/carry vectors ahead of the final adder, which gives 2-cycle latency.
module bwsm_mult #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           out_valid,
  output logic [2*W-1:0] p
);

  localparam int PW = 2 * W;

  // One row of the array for multiplier bit j. Only the cross terms that mix
  // exactly one sign bit are inverted.
  function automatic logic [PW-1:0] ppRow(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input int           j);
    logic [PW-1:0] row;
    logic          bitV;
    row = '0;
    for (int i = 0; i < W; i++) begin
      bitV = a[i] & b[j];
      if ((i == W - 1) != (j == W - 1)) bitV = ~bitV;
      row[i+j] = bitV;
    end
    return row;
  endfunction

  // Carry-save reduction of all rows. The two correction ones seed the sum
  // vector, so each full-adder level absorbs exactly one partial-product row.
  function automatic logic [2*PW-1:0] csaArray(input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    logic [PW-1:0] r;
    logic [PW-1:0] maj;
    s        = '0;
    s[W]     = 1'b1;
    s[PW-1]  = 1'b1;
    c        = '0;
    for (int j = 0; j < W; j++) begin
      r   = ppRow(a, b, j);
      maj = (s & c) | (s & r) | (c & r);
      s   = s ^ c ^ r;
      c   = {maj[PW-2:0], 1'b0};
    end
    return {s, c};
  endfunction

  // Final carry-propagate adder; the carry out of the top bit is dropped.
  function automatic logic [PW-1:0] rippleAdd(input logic [PW-1:0] s,
                                               input logic [PW-1:0] c);
    logic [PW-1:0] sum;
    logic          carry;
    sum   = '0;
    carry = 1'b0;
    for (int k = 0; k < PW; k++) begin
      sum[k] = s[k] ^ c[k] ^ carry;
      carry  = (s[k] & c[k]) | (s[k] & carry) | (c[k] & carry);
    end
    return sum;
  endfunction

  logic [PW-1:0] csaSum;
  logic [PW-1:0] csaCarry;
  logic [PW-1:0] p_d;
  logic [PW-1:0] p_q;
  logic          out_valid_q;

  assign {csaSum, csaCarry} = csaArray(x, y);

`ifdef BWSM_PIPE_EN
  logic [PW-1:0] sum_q;
  logic [PW-1:0] carry_q;
  logic          stg_valid_q;

  assign p_d = rippleAdd(sum_q, carry_q);

  // Data registers load only on valid so idle-cycle operands never reach p.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      carry_q     <= '0;
      stg_valid_q <= 1'b0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      stg_valid_q <= in_valid;
      if (in_valid) begin
        sum_q   <= csaSum;
        carry_q <= csaCarry;
      end
      out_valid_q <= stg_valid_q;
      if (stg_valid_q) p_q <= p_d;
    end
  end
`else
  assign p_d = rippleAdd(csaSum, csaCarry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) p_q <= p_d;
    end
  end
`endif

  assign p         = p_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bwsm_mult.sv
// Directed and exhaustive streaming bench for bwsm_mult at W=4.
module tb_bwsm_mult;

  localparam int W = 4;
`ifdef BWSM_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           out_valid;
  logic [2*W-1:0] p;

  int checkCount = 0;
  int passCount  = 0;

  bwsm_mult #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .p         (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operand pair, then leave the inputs idle until the result is due.
  task automatic applyStimulus(input logic [W-1:0] xa, input logic [W-1:0] ya);
    @(negedge clk);
    in_valid = 1'b1;
    x        = xa;
    y        = ya;
    @(negedge clk);
    in_valid = 1'b0;
    x        = 'x;
    y        = 'x;
    repeat (LAT - 1) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    x        = '0;
    y        = '0;
    #1;
    checkCount++;
    if (p !== 8'h00 || out_valid !== 1'b0)
      $display("[TB] FAIL reset_initial p=%h v=%b required p=00 v=0", p, out_valid);
    else passCount++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    in_valid = 1'b1;
    x        = 4'd7;
    y        = 4'd7;
    repeat (LAT + 1) @(negedge clk);
    checkCount++;
    if (p !== 8'h31 || out_valid !== 1'b1)
      $display("[TB] FAIL reset_prefill p=%h v=%b required p=31 v=1", p, out_valid);
    else passCount++;
    #2 rst_n = 1'b0;
    #1;
    checkCount++;
    if (p !== 8'h00 || out_valid !== 1'b0)
      $display("[TB] FAIL reset_async p=%h v=%b required p=00 v=0", p, out_valid);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (p !== 8'h00 || out_valid !== 1'b0)
      $display("[TB] FAIL reset_held p=%h v=%b required p=00 v=0", p, out_valid);
    else passCount++;

    rst_n    = 1'b1;
    in_valid = 1'b1;
    x        = 4'd2;
    y        = 4'd3;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      x        = 'x;
      y        = 'x;
      checkCount++;
      if (out_valid !== (k == LAT))
        $display("[TB] FAIL reset_latency_valid cycle=%0d v=%b required %b", k, out_valid, (k == LAT));
      else passCount++;
      checkCount++;
      if (p !== ((k == LAT) ? 8'h06 : 8'h00))
        $display("[TB] FAIL reset_latency_p cycle=%0d p=%h", k, p);
      else passCount++;
    end
  endtask

  task automatic test_positive;
    logic [3:0] tx [4] = '{4'd0, 4'd1, 4'd2, 4'd7};
    logic [3:0] ty [4] = '{4'd0, 4'd1, 4'd3, 4'd5};
    logic [7:0] te [4] = '{8'h00, 8'h01, 8'h06, 8'h23};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(tx[i], ty[i]);
      checkCount++;
      if (out_valid !== 1'b1 || p !== te[i])
        $display("[TB] FAIL positive x=%h y=%h p=%h v=%b required p=%h v=1", tx[i], ty[i], p, out_valid, te[i]);
      else passCount++;
    end
  endtask

  task automatic test_mixed;
    logic [3:0] tx [2] = '{4'b1111, 4'b1001};
    logic [3:0] ty [2] = '{4'b0001, 4'b0110};
    logic [7:0] te [2] = '{8'hFF, 8'hD6};
    for (int i = 0; i < 2; i++) begin
      applyStimulus(tx[i], ty[i]);
      checkCount++;
      if (out_valid !== 1'b1 || p !== te[i])
        $display("[TB] FAIL mixed x=%h y=%h p=%h v=%b required p=%h v=1", tx[i], ty[i], p, out_valid, te[i]);
      else passCount++;
    end
  endtask

  task automatic test_negative;
    logic [3:0] tx [3] = '{4'b1100, 4'b1010, 4'b1111};
    logic [3:0] ty [3] = '{4'b1100, 4'b1011, 4'b1111};
    logic [7:0] te [3] = '{8'h10, 8'h1E, 8'h01};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(tx[i], ty[i]);
      checkCount++;
      if (out_valid !== 1'b1 || p !== te[i])
        $display("[TB] FAIL negative x=%h y=%h p=%h v=%b required p=%h v=1", tx[i], ty[i], p, out_valid, te[i]);
      else passCount++;
    end
  endtask

  task automatic test_extremes;
    applyStimulus(4'b1000, 4'b1000);
    checkCount++;
    if (out_valid !== 1'b1 || p !== 8'h40)
      $display("[TB] FAIL extreme_neg_neg p=%h v=%b required p=40 v=1", p, out_valid);
    else passCount++;
    applyStimulus(4'b1000, 4'b0111);
    checkCount++;
    if (out_valid !== 1'b1 || p !== 8'hC8)
      $display("[TB] FAIL extreme_neg_pos p=%h v=%b required p=c8 v=1", p, out_valid);
    else passCount++;
  endtask

  // p must hold the last product while idle inputs carry garbage.
  task automatic test_hold;
    applyStimulus(4'd7, 4'd5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      x = 4'($urandom);
      y = 4'($urandom);
      checkCount++;
      if (out_valid !== 1'b0 || p !== 8'h23)
        $display("[TB] FAIL hold cycle=%0d p=%h v=%b required p=23 v=0", k, p, out_valid);
      else passCount++;
    end
    x = 'x;
    y = 'x;
  endtask

  task automatic test_back_to_back;
    logic       qV [$];
    logic [7:0] qP [$];
    logic       ev;
    logic [7:0] ep;
    logic [3:0] xa;
    logic [3:0] ya;
    int         idx;
    int         cyc;
    int         prod;
    idx = 0;
    cyc = 0;
    in_valid = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    for (int k = 0; k < LAT; k++) begin
      qV.push_back(1'b0);
      qP.push_back(8'h00);
    end
    while ((idx < 256 || qV.size() > 0) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      ev = qV.pop_front();
      ep = qP.pop_front();
      checkCount++;
      if (out_valid !== ev)
        $display("[TB] FAIL stream_valid cycle=%0d v=%b required %b", cyc, out_valid, ev);
      else passCount++;
      if (ev) begin
        checkCount++;
        if (p !== ep)
          $display("[TB] FAIL stream_p cycle=%0d p=%h required %h", cyc, p, ep);
        else passCount++;
      end
      if (idx < 256 && $urandom_range(0, 3) != 0) begin
        xa       = idx[7:4];
        ya       = idx[3:0];
        prod     = $signed(xa) * $signed(ya);
        in_valid = 1'b1;
        x        = xa;
        y        = ya;
        qV.push_back(1'b1);
        qP.push_back(prod[7:0]);
        idx++;
      end else begin
        in_valid = 1'b0;
        x        = 'x;
        y        = 'x;
        if (idx < 256) begin
          qV.push_back(1'b0);
          qP.push_back(8'h00);
        end
      end
    end
    in_valid = 1'b0;
    checkCount++;
    if (cyc >= 2000)
      $display("[TB] FAIL stream_timeout issued=%0d required 256", idx);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_positive();
    test_mixed();
    test_negative();
    test_extremes();
    test_hold();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bwsm_mult.md
Name: bwsm_mult

Overview:
- Signed two's-complement multiplier using the Baugh-Wooley partial-product array; computes p = x * y.
- Operands are W bits; the product is full-precision 2W bits.
- Output is registered with a valid strobe.
- Sits in datapath arithmetic as a drop-in signed multiply stage for small-width DSP/ALU paths.

Parameters:
- W, 4, operand width in bits (≥2); product width is 2W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  x/y valid this cycle; sampled on the rising edge.
- x  input  W  signed multiplicand, two's complement.
- y  input  W  signed multiplier, two's complement.
- out_valid  output  1  p holds the product of an accepted operand pair.
- p  output  2W  signed product, two's complement.

Behaviour:
- Reset: while rst_n=0, p=0 and out_valid=0, asynchronously and regardless of clk. Release is synchronous to the next clk edge; no operation is accepted on the releasing edge unless in_valid=1 at that edge.
- Array construction (combinational, no `*` operator):
  - Partial products a_i·b_j for i,j < W-1, plus a_{W-1}·b_{W-1}, at weight 2^(i+j).
  - Inverted terms ~(a_{W-1}·b_j) for j < W-1, at weight 2^(W-1+j).
  - Inverted terms ~(a_i·b_{W-1}) for i < W-1, at weight 2^(i+W-1).
  - Correction constants 1 at bit W and 1 at bit 2W-1.
  - Sum through a carry-save full-adder array; final ripple adder.
  - Keep result bits [2W-1:0]; discard the carry out of bit 2W-1.
- Latency: 1 cycle.
  - On a rising edge with in_valid=1: p <= x*y and out_valid <= 1.
  - On a rising edge with in_valid=0: out_valid <= 0 and p holds its previous value.
- Throughput: one product per cycle. No backpressure; the consumer must take p in the cycle out_valid=1.
- Range: full-precision result with no overflow. Extremes for W=4 are (-8)*(-8)=+64 (8'h40) and (-8)*7=-56 (8'hC8).
- Reset asserted mid-stream: any in-flight result is discarded; p=0 and out_valid=0 immediately.
- X/Z on x or y while in_valid=0 must not affect p.

Optional Feature:
- Macro: BWSM_PIPE_EN.
- Defined:
  - Adds a pipeline register between the carry-save array output (sum and carry vectors) and the final ripple adder.
  - Latency becomes 2 cycles; throughput stays one product per cycle.
  - A valid bit travels alongside the data. Both stages reset to 0 asynchronously.
- Undefined: single-stage datapath, 1-cycle latency as described above.
- Functional results are identical in both modes; only latency differs.

Test Plan:
- Reset: assert rst_n=0 mid-operation with in_valid=1 → p=8'h00 and out_valid=0 immediately; after release, the first valid operation produces a result after the configured latency.
- Positive operands (W=4):
  - x=0,y=0 → p=8'b00000000.
  - x=1,y=1 → 8'b00000001.
  - x=2,y=3 → 8'b00000110.
  - x=7,y=5 → 8'b00100011.
- Mixed signs:
  - x=4'b1111,y=4'b0001 → 8'b11111111 (-1).
  - x=4'b1001,y=4'b0110 → 8'b11010110 (-42).
- Both negative:
  - x=4'b1100,y=4'b1100 → 8'b00010000 (16).
  - x=4'b1010,y=4'b1011 → 8'b00011110 (30).
  - x=4'b1111,y=4'b1111 → 8'b00000001.
- Extremes: x=4'b1000,y=4'b1000 → 8'b01000000; x=4'b1000,y=4'b0111 → 8'b11001000.
- Streaming and exhaustive: back-to-back in_valid for all 256 (x,y) pairs, with random in_valid gaps, compared against a signed reference model → every output matches and out_valid tracks in_valid delayed by the latency (1, or 2 with BWSM_PIPE_EN).
